i2c_slave_regs: RTL

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

---
 rtl/i2c_slave_pkg.sv | 24 ++
 rtl/i2c_slave_sync_edge.sv | 45 ++++
 rtl/i2c_slave_regs.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file slave.
package i2c_slave_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  // Value of the R/W bit that follows the address.
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

endpackage

// File: rtl/i2c_slave_sync_edge.sv
// Brings SCL/SDA into the clk_i domain and flags SCL edges and START/STOP.
module i2c_slave_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;
  logic       scl_s;
  logic       sda_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // SDA may only move while SCL is high for a bus condition.
  assign start_o    = sda_prev_q & ~sda_s & scl_s & scl_prev_q;
  assign stop_o     = ~sda_prev_q & sda_s & scl_s & scl_prev_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing MEM_DEPTH byte registers behind an auto-incrementing pointer.
module i2c_slave_regs
  import i2c_slave_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h22,
  parameter int                    MEM_DEPTH  = 16,
  localparam int                   PTR_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_o,
  output logic                  sda_o,
  output logic                  wr_valid_o,
  output logic [PTR_W-1:0]      wr_addr_o,
  output logic [I2C_DATA_W-1:0] wr_data_o,
  output logic                  busy_o,
  output state_t                state_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_sync_edge u_sync_edge (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_t                  state_q, state_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic [I2C_DATA_W-1:0]   shreg_q, shreg_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic                    sda_q, sda_d;
  logic                    ack_seen_q, ack_seen_d;
  logic                    rw_q, rw_d;
  logic                    busy_q, busy_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [PTR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [I2C_DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [I2C_DATA_W-1:0]   mem_q [MEM_DEPTH];
  logic                    mem_we;
  logic [I2C_DATA_W-1:0]   byte_in;

  assign byte_in = {shreg_q[I2C_DATA_W-2:0], sda_s};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      ptr_q      <= '0;
      sda_q      <= 1'b1;
      ack_seen_q <= 1'b0;
      rw_q       <= RW_WRITE;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      ptr_q      <= ptr_d;
      sda_q      <= sda_d;
      ack_seen_q <= ack_seen_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[ptr_q] <= byte_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    ptr_d      = ptr_q;
    sda_d      = sda_q;
    ack_seen_d = ack_seen_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;

    if (stop_det) begin
      state_d   = IDLE;
      sda_d     = 1'b1;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_det) begin
      state_d   = ADDR;
      sda_d     = 1'b1;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ADDR, PTR, WR_DATA: begin
          if (scl_rise) begin
            shreg_d    = byte_in;
            bit_cnt_d  = bit_cnt_q + 4'd1;
            ack_seen_d = 1'b0;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ADDR) begin
                // General call (all-zero address) is never answered.
                if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != '0) begin
                  state_d = ADDR_ACK;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == PTR) begin
                ptr_d   = byte_in[PTR_W-1:0];
                state_d = PTR_ACK;
              end else begin
                mem_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + PTR_ONE;
                state_d    = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          // First falling edge starts the ACK bit, the second one ends it.
          if (scl_rise) begin
            ack_seen_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_seen_q) begin
              sda_d = 1'b0;
            end else begin
              sda_d     = 1'b1;
              bit_cnt_d = '0;
              if (state_q == ADDR_ACK && rw_q == RW_READ) begin
                shreg_d = mem_q[ptr_q];
                sda_d   = mem_q[ptr_q][7];
                state_d = RD_DATA;
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_d      = 1'b1;
              ack_seen_d = 1'b0;
              state_d    = RD_ACK;
            end else begin
              sda_d   = shreg_q[6];
              shreg_d = {shreg_q[I2C_DATA_W-2:0], 1'b0};
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              ptr_d      = ptr_q + PTR_ONE;
              ack_seen_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else if (scl_fall && ack_seen_q) begin
            shreg_d   = mem_q[ptr_q];
            sda_d     = mem_q[ptr_q][7];
            bit_cnt_d = '0;
            state_d   = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  // wr_valid_o is a one-cycle notification with no backpressure: the consumer
  // must take wr_addr_o/wr_data_o in the cycle wr_valid_o is high.
  assign scl_o      = 1'b1;
  assign sda_o      = sda_q;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign state_o    = state_q;

endmodule
